mem_dump: RTL

MEM_DUMP -- requirements
Module: mem_dump

---
 rtl/mem_dump.sv | 122 ++++++++++++
 1 files changed

// File: rtl/mem_dump.sv
// Memory dump engine: reads words from a 1-cycle synchronous RAM and
// streams them out little-endian, followed by an XOR checksum byte.
module mem_dump #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] word_count,
  output logic             busy,
  output logic             done,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  input  logic [31:0]      mem_rdata,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_SEND,
    S_CSUM
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [31:0]      addr;
  logic [31:0]      word_buf;
  logic [CNT_W-1:0] remaining;
  logic [1:0]       idx;
  logic [7:0]       csum;
  logic             xfer;

  assign xfer = tx_valid && tx_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (start)
          state_nx = (word_count != '0) ? S_REQ : S_CSUM;
      end
      S_REQ:  state_nx = S_WAIT;
      S_WAIT: state_nx = S_SEND;
      S_SEND: begin
        // remaining is still the pre-decrement value here
        if (xfer && idx == 2'd3)
          state_nx = (remaining == CNT_W'(1)) ? S_CSUM : S_REQ;
      end
      S_CSUM: begin
        if (xfer) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= '0;
      word_buf  <= '0;
      remaining <= '0;
      idx       <= '0;
      csum      <= '0;
      done      <= 1'b0;
    end else begin
      done <= (state == S_CSUM) && xfer;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            addr      <= base_addr & ~32'h3;
            remaining <= word_count;
            csum      <= '0;
          end
        end
        S_WAIT: begin
          word_buf <= mem_rdata;
          idx      <= '0;
        end
        S_SEND: begin
          if (xfer) begin
            csum <= csum ^ tx_data;
            idx  <= idx + 2'd1;
            if (idx == 2'd3) begin
              remaining <= remaining - CNT_W'(1);
              addr      <= addr + 32'd4;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy     = (state != S_IDLE);
    mem_req  = (state == S_REQ);
    mem_addr = addr;
    tx_valid = (state == S_SEND) || (state == S_CSUM);
    tx_data  = '0;
    if (state == S_SEND) begin
      unique case (idx)
        2'd0: tx_data = word_buf[7:0];
        2'd1: tx_data = word_buf[15:8];
        2'd2: tx_data = word_buf[23:16];
        2'd3: tx_data = word_buf[31:24];
        default: tx_data = '0;
      endcase
    end else if (state == S_CSUM) begin
      tx_data = csum;
    end
  end

endmodule
